// File: rtl/bus_dma.sv
// Memory-to-memory word copier: a CPU-programmed register block on the responder
// side drives an initiator port that reads SRC, then writes DST, one word per 3 cycles.
module bus_dma #(
    parameter int BITS = 32,
    parameter logic [BITS-1:0] BASE = 32'hF0000200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic            re,
    input  logic [BITS-1:0] memAddr,
    input  logic [BITS-1:0] dataBusIn,
    output logic [BITS-1:0] dataBusOut,
    output logic            busReq,
    input  logic            busGnt,
    output logic [BITS-1:0] mAddr,
    output logic            mRe,
    output logic            mWe,
    output logic [BITS-1:0] mDataOut,
    input  logic [BITS-1:0] mDataIn
);
    localparam logic [BITS-1:0] ADDR_SRC  = BASE;
    localparam logic [BITS-1:0] ADDR_DST  = BASE + BITS'(4);
    localparam logic [BITS-1:0] ADDR_LEN  = BASE + BITS'(8);
    localparam logic [BITS-1:0] ADDR_CTRL = BASE + BITS'(12);

    typedef enum logic [2:0] {IDLE, REQ, RD, CAP, WR} stateType;

    stateType        stateReg, stateNext;
    logic [BITS-1:0] srcReg, srcNext;
    logic [BITS-1:0] dstReg, dstNext;
    logic [15:0]     lenReg, lenNext;
    logic [BITS-1:0] bufReg, bufNext;
    logic            doneReg, doneNext;

    logic busy;
    logic hitSrc, hitDst, hitLen, hitCtrl;
    logic ctrlWrite, startReq, clearReq;

    assign busy      = (stateReg != IDLE);
    assign hitSrc    = (memAddr == ADDR_SRC);
    assign hitDst    = (memAddr == ADDR_DST);
    assign hitLen    = (memAddr == ADDR_LEN);
    assign hitCtrl   = (memAddr == ADDR_CTRL);
    assign ctrlWrite = we && hitCtrl;
    assign startReq  = ctrlWrite && dataBusIn[0];
    assign clearReq  = ctrlWrite && dataBusIn[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
            srcReg   <= '0;
            dstReg   <= '0;
            lenReg   <= '0;
            bufReg   <= '0;
            doneReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            srcReg   <= srcNext;
            dstReg   <= dstNext;
            lenReg   <= lenNext;
            bufReg   <= bufNext;
            doneReg  <= doneNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        srcNext   = srcReg;
        dstNext   = dstReg;
        lenNext   = lenReg;
        bufNext   = bufReg;
        doneNext  = doneReg;
        busReq    = 1'b0;
        mRe       = 1'b0;
        mWe       = 1'b0;
        mAddr     = '0;
        mDataOut  = '0;

        // Clear is applied first so that a completion below overrides it.
        if (clearReq) begin
            doneNext = 1'b0;
        end

        case (stateReg)
            IDLE: begin
                // Register loads are only decoded here, which makes them inert while busy.
                if (we && hitSrc) srcNext = {dataBusIn[BITS-1:2], 2'b00};
                if (we && hitDst) dstNext = {dataBusIn[BITS-1:2], 2'b00};
                if (we && hitLen) lenNext = dataBusIn[15:0];
                if (startReq) begin
                    if (lenReg == 16'd0) begin
                        doneNext = 1'b1;
                    end else begin
                        doneNext  = 1'b0;
                        stateNext = REQ;
                    end
                end
            end
            REQ: begin
                busReq = 1'b1;
                if (busGnt) stateNext = RD;
            end
            RD: begin
                busReq    = 1'b1;
                mRe       = 1'b1;
                mAddr     = srcReg;
                stateNext = CAP;
            end
            CAP: begin
                busReq    = 1'b1;
                bufNext   = mDataIn;
                stateNext = WR;
            end
            WR: begin
                busReq   = 1'b1;
                mWe      = 1'b1;
                mAddr    = dstReg;
                mDataOut = bufReg;
                srcNext  = srcReg + BITS'(4);
                dstNext  = dstReg + BITS'(4);
                lenNext  = lenReg - 16'd1;
                // Grant is only looked at here, at the word boundary.
                if (lenReg == 16'd1) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end else if (busGnt) begin
                    stateNext = RD;
                end else begin
                    stateNext = REQ;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        dataBusOut = '0;
        if (re && !we) begin
            if (hitSrc)  dataBusOut = srcReg;
            if (hitDst)  dataBusOut = dstReg;
            if (hitLen)  dataBusOut = {{(BITS-16){1'b0}}, lenReg};
            if (hitCtrl) dataBusOut = {{(BITS-2){1'b0}}, doneReg, busy};
        end
    end
endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: register access, copy ordering/timing, grant loss,
// address wrap, busy-write masking, clear-vs-completion and mid-transfer reset.
module tb_bus_dma;
    localparam logic [31:0] A_SRC  = 32'hF000_0200;
    localparam logic [31:0] A_DST  = 32'hF000_0204;
    localparam logic [31:0] A_LEN  = 32'hF000_0208;
    localparam logic [31:0] A_CTRL = 32'hF000_020C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] memAddr = '0;
    logic [31:0] dataBusIn = '0;
    logic [31:0] dataBusOut;
    logic        busReq;
    logic        busGnt = 1'b0;
    logic [31:0] mAddr;
    logic        mRe;
    logic        mWe;
    logic [31:0] mDataOut;
    logic [31:0] mDataIn = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int firstRd = -1;
    int doneCyc = -1;
    logic bothSeen = 1'b0;
    logic leakSeen = 1'b0;
    logic reqSeen = 1'b0;
    logic [31:0] rdAddrQ[$];
    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];
    logic [31:0] rdVal;

    bus_dma #(.BITS(32), .BASE(32'hF000_0200)) dut (
        .clk(clk), .reset(reset), .we(we), .re(re), .memAddr(memAddr),
        .dataBusIn(dataBusIn), .dataBusOut(dataBusOut), .busReq(busReq),
        .busGnt(busGnt), .mAddr(mAddr), .mRe(mRe), .mWe(mWe),
        .mDataOut(mDataOut), .mDataIn(mDataIn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Source memory: each word holds its own address xor a fixed pattern.
    always @(posedge clk) mDataIn <= mRe ? (mAddr ^ 32'hA5A5_0000) : 32'h0;

    always @(negedge clk) begin
        if (mRe) begin
            rdAddrQ.push_back(mAddr);
            if (firstRd < 0) firstRd = cyc;
        end
        if (mWe) begin
            wrAddrQ.push_back(mAddr);
            wrDataQ.push_back(mDataOut);
        end
        if (mRe && mWe) bothSeen = 1'b1;
        if (!mRe && !mWe && mAddr != 32'h0) leakSeen = 1'b1;
        if (!mWe && mDataOut != 32'h0) leakSeen = 1'b1;
        if (busReq) reqSeen = 1'b1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic regWrite(input logic [31:0] a, input logic [31:0] d);
        memAddr = a; dataBusIn = d; we = 1'b1; re = 1'b0;
        @(posedge clk); #1;
        we = 1'b0; dataBusIn = '0; memAddr = '0;
    endtask

    task automatic regRead(input logic [31:0] a, output logic [31:0] d);
        memAddr = a; we = 1'b0; re = 1'b1;
        #1;
        d = dataBusOut;
        re = 1'b0; memAddr = '0;
    endtask

    task automatic clearLog();
        rdAddrQ.delete(); wrAddrQ.delete(); wrDataQ.delete();
        firstRd = -1; doneCyc = -1; reqSeen = 1'b0;
    endtask

    // Poll CTRL each cycle until idle; a timeout shows up as a failed check.
    task automatic waitIdle(input string tag, input int budget);
        int n;
        n = 0;
        memAddr = A_CTRL; we = 1'b0; re = 1'b1;
        while (n < budget) begin
            @(posedge clk); #1;
            n++;
            if (dataBusOut[1] && doneCyc < 0) doneCyc = cyc;
            if (!dataBusOut[0]) break;
        end
        checkVal({tag, "_idle"}, {31'b0, dataBusOut[0]}, 32'h0);
        re = 1'b0; memAddr = '0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_busreq", {31'b0, busReq}, 32'h0);
        checkVal("rst_strobes", {30'b0, mRe, mWe}, 32'h0);
        regRead(A_CTRL, rdVal); checkVal("rst_ctrl", rdVal, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        regRead(A_SRC, rdVal); checkVal("rst_src", rdVal, 32'h0);
        regRead(A_LEN, rdVal); checkVal("rst_len", rdVal, 32'h0);
        checkVal("no_read_bus", dataBusOut, 32'h0);

        // Alignment of SRC/DST, LEN truncation
        regWrite(A_SRC, 32'h0000_0103);
        regRead(A_SRC, rdVal); checkVal("src_align", rdVal, 32'h0000_0100);
        regWrite(A_LEN, 32'hABCD_0003);
        regRead(A_LEN, rdVal); checkVal("len_trunc", rdVal, 32'h0000_0003);

        // Three-word copy under continuous grant
        regWrite(A_DST, 32'h0000_0200);
        busGnt = 1'b1;
        clearLog();
        regWrite(A_CTRL, 32'h1);
        waitIdle("copy3", 40);
        checkVal("copy3_nrd", rdAddrQ.size(), 32'd3);
        checkVal("copy3_rd0", rdAddrQ[0], 32'h0000_0100);
        checkVal("copy3_rd1", rdAddrQ[1], 32'h0000_0104);
        checkVal("copy3_rd2", rdAddrQ[2], 32'h0000_0108);
        checkVal("copy3_nwr", wrAddrQ.size(), 32'd3);
        checkVal("copy3_wa0", wrAddrQ[0], 32'h0000_0200);
        checkVal("copy3_wa2", wrAddrQ[2], 32'h0000_0208);
        checkVal("copy3_wd0", wrDataQ[0], 32'hA5A5_0100);
        checkVal("copy3_wd1", wrDataQ[1], 32'hA5A5_0104);
        checkVal("copy3_wd2", wrDataQ[2], 32'hA5A5_0108);
        checkVal("copy3_latency", doneCyc - firstRd, 32'd9);
        regRead(A_CTRL, rdVal); checkVal("copy3_ctrl", rdVal, 32'h2);
        regRead(A_SRC, rdVal); checkVal("copy3_src", rdVal, 32'h0000_010C);
        regRead(A_DST, rdVal); checkVal("copy3_dst", rdVal, 32'h0000_020C);

        // Done clear, then zero-length start
        regWrite(A_CTRL, 32'h2);
        regRead(A_CTRL, rdVal); checkVal("done_clear", rdVal, 32'h0);
        regWrite(A_LEN, 32'h0);
        clearLog();
        regWrite(A_CTRL, 32'h1);
        regRead(A_CTRL, rdVal); checkVal("len0_ctrl", rdVal, 32'h2);
        repeat (4) @(posedge clk);
        #1;
        checkVal("len0_busreq", {31'b0, reqSeen}, 32'h0);
        checkVal("len0_nrd", rdAddrQ.size() + wrAddrQ.size(), 32'd0);

        // Grant dropped during second word's CAP
        regWrite(A_SRC, 32'h0000_0300);
        regWrite(A_DST, 32'h0000_0400);
        regWrite(A_LEN, 32'h4);
        clearLog();
        regWrite(A_CTRL, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        busGnt = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkVal("hold_nwr", wrAddrQ.size(), 32'd2);
        checkVal("hold_nrd", rdAddrQ.size(), 32'd2);
        checkVal("hold_busreq", {31'b0, busReq}, 32'h1);
        checkVal("hold_strobes", {30'b0, mRe, mWe}, 32'h0);
        regRead(A_CTRL, rdVal); checkVal("hold_ctrl", rdVal, 32'h1);
        busGnt = 1'b1;
        waitIdle("resume", 30);
        checkVal("resume_nrd", rdAddrQ.size(), 32'd4);
        checkVal("resume_rd2", rdAddrQ[2], 32'h0000_0308);
        checkVal("resume_wa3", wrAddrQ[3], 32'h0000_040C);
        checkVal("resume_wd3", wrDataQ[3], 32'hA5A5_030C);

        // Source address wrap
        regWrite(A_SRC, 32'hFFFF_FFFC);
        regWrite(A_DST, 32'h0000_0500);
        regWrite(A_LEN, 32'h2);
        clearLog();
        regWrite(A_CTRL, 32'h1);
        waitIdle("wrap", 30);
        checkVal("wrap_rd0", rdAddrQ[0], 32'hFFFF_FFFC);
        checkVal("wrap_rd1", rdAddrQ[1], 32'h0000_0000);
        checkVal("wrap_wd1", wrDataQ[1], 32'hA5A5_0000);
        regRead(A_SRC, rdVal); checkVal("wrap_src", rdVal, 32'h0000_0004);

        // Writes while busy are ignored
        regWrite(A_SRC, 32'h0000_0600);
        regWrite(A_DST, 32'h0000_0700);
        regWrite(A_LEN, 32'h3);
        clearLog();
        regWrite(A_CTRL, 32'h1);
        regWrite(A_SRC, 32'h0000_0900);
        regWrite(A_CTRL, 32'h1);
        regWrite(A_LEN, 32'h9);
        waitIdle("busyw", 40);
        checkVal("busyw_nrd", rdAddrQ.size(), 32'd3);
        checkVal("busyw_rd0", rdAddrQ[0], 32'h0000_0600);
        checkVal("busyw_rd2", rdAddrQ[2], 32'h0000_0608);
        regRead(A_SRC, rdVal); checkVal("busyw_src", rdVal, 32'h0000_060C);
        regRead(A_LEN, rdVal); checkVal("busyw_len", rdVal, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        regRead(A_CTRL, rdVal); checkVal("busyw_ctrl", rdVal, 32'h2);

        // Done-clear in the completing cycle loses to completion
        regWrite(A_SRC, 32'h0000_0A00);
        regWrite(A_DST, 32'h0000_0B00);
        regWrite(A_LEN, 32'h1);
        regWrite(A_CTRL, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        checkVal("race_in_wr", {31'b0, mWe}, 32'h1);
        regWrite(A_CTRL, 32'h2);
        regRead(A_CTRL, rdVal); checkVal("race_ctrl", rdVal, 32'h2);

        // Reset during WR of word 2 of 5
        regWrite(A_SRC, 32'h0000_0800);
        regWrite(A_DST, 32'h0000_0900);
        regWrite(A_LEN, 32'h5);
        regWrite(A_CTRL, 32'h1);
        repeat (6) @(posedge clk);
        #1;
        checkVal("prerst_mwe", {31'b0, mWe}, 32'h1);
        reset = 1'b1;
        #1;
        checkVal("rstmid_busreq", {31'b0, busReq}, 32'h0);
        checkVal("rstmid_strobes", {30'b0, mRe, mWe}, 32'h0);
        checkVal("rstmid_maddr", mAddr, 32'h0);
        checkVal("rstmid_mdata", mDataOut, 32'h0);
        regRead(A_CTRL, rdVal); checkVal("rstmid_ctrl", rdVal, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clearLog();
        repeat (5) @(posedge clk);
        #1;
        checkVal("postrst_nstrobe", rdAddrQ.size() + wrAddrQ.size(), 32'd0);
        checkVal("postrst_busreq", {31'b0, reqSeen}, 32'h0);
        regRead(A_CTRL, rdVal); checkVal("postrst_ctrl", rdVal, 32'h0);
        regRead(A_SRC, rdVal); checkVal("postrst_src", rdVal, 32'h0);
        regRead(A_LEN, rdVal); checkVal("postrst_len", rdVal, 32'h0);

        // Bus hygiene over the whole run
        checkVal("never_both_strobes", {31'b0, bothSeen}, 32'h0);
        checkVal("idle_bus_zero", {31'b0, leakSeen}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
